// File: rtl/rv32i_types.sv
// Shared types for the RV32I out-of-order core.
// Holds the reorder-buffer geometry, the writeback port numbering and the
// ROB entry image that travels from dispatch through writeback to commit.
package rv32i_types;

  localparam int ROB_DEPTH = 32;
  localparam int ROB_IDX_W = 5;

  typedef enum logic [1:0] {
    empty,
    rob_wait,
    done
  } status_t;

  typedef enum logic [1:0] {
    alu,
    mul,
    br,
    mem
  } types_t;

  // Writeback port numbering; the index is also the priority on a collision
  // (higher number wins).
  typedef enum logic [1:0] {
    WB_ALU,
    WB_MUL,
    WB_BR,
    WB_MEM
  } wb_port_t;

  typedef struct packed {
    logic        valid;
    status_t     status;
    types_t      op_type;
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        br_en;
    logic [31:0] pc_new;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer.
// Dispatch allocates at the tail, four writeback ports (alu, mul, br, mem)
// mark entries done, and the head retires in program order. A taken branch
// that reaches the head raises flush and empties the buffer.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   dispatch_valid/_entry    allocation request and entry image
//   dispatch_ready           not full
//   dispatch_rob_idx         index the next allocation receives
//   wb_valid/_rob_idx/_data  per-port writeback (lane p = port p)
//   wb_br_en/_br_target      branch outcome, port 2 only
//   rs1/rs2_lookup_*         operand lookup by ROB index (registered state)
//   commit_valid/_entry      head entry retiring this cycle
//   flush/flush_pc           redirect on a committing taken branch
module reorder_buffer
  import rv32i_types::*;
#(
  parameter int NUM_WB = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dispatch_valid,
  input  rob_entry_t                    dispatch_entry,
  output logic                          dispatch_ready,
  output logic [ROB_IDX_W-1:0]          dispatch_rob_idx,
  input  logic [NUM_WB-1:0]             wb_valid,
  input  logic [NUM_WB*ROB_IDX_W-1:0]   wb_rob_idx,
  input  logic [NUM_WB*32-1:0]          wb_data,
  input  logic                          wb_br_en,
  input  logic [31:0]                   wb_br_target,
  input  logic [ROB_IDX_W-1:0]          rs1_lookup_idx,
  output logic [31:0]                   rs1_lookup_data,
  output logic                          rs1_lookup_ready,
  input  logic [ROB_IDX_W-1:0]          rs2_lookup_idx,
  output logic [31:0]                   rs2_lookup_data,
  output logic                          rs2_lookup_ready,
  output logic                          commit_valid,
  output rob_entry_t                    commit_entry,
  output logic                          flush,
  output logic [31:0]                   flush_pc
);

  // Control state (reset): occupancy and status per entry, pointers.
  logic [ROB_DEPTH-1:0]   valid_q;
  status_t                status_q [ROB_DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [ROB_IDX_W:0]     head_q;
  logic [ROB_IDX_W:0]     tail_q;
  // Payload (not reset): only meaningful while valid_q is set.
  rob_entry_t             payload_q [ROB_DEPTH];

  logic [ROB_IDX_W-1:0]   head_idx;
  logic [ROB_IDX_W-1:0]   tail_idx;
  logic                   full;
  logic                   dispatch_fire;
  rob_entry_t             dispatch_img;
  logic [ROB_IDX_W-1:0]   wb_idx [NUM_WB];
  logic [31:0]            wb_dat [NUM_WB];

  assign head_idx = head_q[ROB_IDX_W-1:0];
  assign tail_idx = tail_q[ROB_IDX_W-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[ROB_IDX_W] != tail_q[ROB_IDX_W]);

  assign dispatch_ready   = !full;
  assign dispatch_rob_idx = tail_idx;
  assign dispatch_fire    = dispatch_valid && !full && !flush;

  always_comb begin
    for (int p = 0; p < NUM_WB; p++) begin
      wb_idx[p] = wb_rob_idx[p*ROB_IDX_W +: ROB_IDX_W];
      wb_dat[p] = wb_data[p*32 +: 32];
    end
  end

  always_comb begin
    dispatch_img        = dispatch_entry;
    dispatch_img.valid  = 1'b1;
    dispatch_img.status = rob_wait;
    dispatch_img.br_en  = 1'b0;
  end

  // Head entry, with the control fields taken from the reset-managed state.
  always_comb begin
    commit_entry        = payload_q[head_idx];
    commit_entry.valid  = valid_q[head_idx];
    commit_entry.status = status_q[head_idx];
  end

  assign commit_valid = valid_q[head_idx] && (status_q[head_idx] == done);
  assign flush        = commit_valid && (commit_entry.op_type == br) && commit_entry.br_en;
  assign flush_pc     = flush ? commit_entry.pc_new : 32'd0;

  // Lookups see registered state only; a same-cycle writeback is not bypassed.
  assign rs1_lookup_data  = payload_q[rs1_lookup_idx].rd_data;
  assign rs1_lookup_ready = valid_q[rs1_lookup_idx] && (status_q[rs1_lookup_idx] == done);
  assign rs2_lookup_data  = payload_q[rs2_lookup_idx].rd_data;
  assign rs2_lookup_ready = valid_q[rs2_lookup_idx] && (status_q[rs2_lookup_idx] == done);

  // Control update: reset > flush > (writeback, commit, dispatch).
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        status_q[i] <= empty;
      end
    end else if (flush) begin
      // Everything younger than the branch is discarded; restart just past it.
      for (int i = 0; i < ROB_DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        status_q[i] <= empty;
      end
      head_q <= head_q + 1'b1;
      tail_q <= head_q + 1'b1;
    end else begin
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid[p] && valid_q[wb_idx[p]]) begin
          status_q[wb_idx[p]] <= done;
        end
      end
      // Commit after writeback so a late write to the head cannot revive it.
      if (commit_valid) begin
        valid_q[head_idx]  <= 1'b0;
        status_q[head_idx] <= empty;
        head_q             <= head_q + 1'b1;
      end
      // The tail slot is never the head slot here (full blocks dispatch).
      if (dispatch_fire) begin
        valid_q[tail_idx]  <= 1'b1;
        status_q[tail_idx] <= rob_wait;
        tail_q             <= tail_q + 1'b1;
      end
    end
  end

  // Payload update; ascending port order lets the higher port win a collision.
  always_ff @(posedge clk) begin
    if (dispatch_fire) begin
      payload_q[tail_idx] <= dispatch_img;
    end
    if (!flush) begin
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid[p] && valid_q[wb_idx[p]]) begin
          payload_q[wb_idx[p]].rd_data <= wb_dat[p];
          if (p == int'(WB_BR)) begin
            payload_q[wb_idx[p]].br_en  <= wb_br_en;
            payload_q[wb_idx[p]].pc_new <= wb_br_target;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: directed stimulus, commit scoreboard.
module tb_reorder_buffer;
  import rv32i_types::*;

  localparam int NUM_WB = 4;
  localparam int IW     = ROB_IDX_W;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     dispatch_valid;
  rob_entry_t               dispatch_entry;
  logic                     dispatch_ready;
  logic [IW-1:0]            dispatch_rob_idx;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*IW-1:0]     wb_rob_idx;
  logic [NUM_WB*32-1:0]     wb_data;
  logic                     wb_br_en;
  logic [31:0]              wb_br_target;
  logic [IW-1:0]            rs1_lookup_idx;
  logic [31:0]              rs1_lookup_data;
  logic                     rs1_lookup_ready;
  logic [IW-1:0]            rs2_lookup_idx;
  logic [31:0]              rs2_lookup_data;
  logic                     rs2_lookup_ready;
  logic                     commit_valid;
  rob_entry_t               commit_entry;
  logic                     flush;
  logic [31:0]              flush_pc;

  always #5 clk = ~clk;

  reorder_buffer #(.NUM_WB(NUM_WB)) dut (
    .clk              (clk),
    .rst              (rst),
    .dispatch_valid   (dispatch_valid),
    .dispatch_entry   (dispatch_entry),
    .dispatch_ready   (dispatch_ready),
    .dispatch_rob_idx (dispatch_rob_idx),
    .wb_valid         (wb_valid),
    .wb_rob_idx       (wb_rob_idx),
    .wb_data          (wb_data),
    .wb_br_en         (wb_br_en),
    .wb_br_target     (wb_br_target),
    .rs1_lookup_idx   (rs1_lookup_idx),
    .rs1_lookup_data  (rs1_lookup_data),
    .rs1_lookup_ready (rs1_lookup_ready),
    .rs2_lookup_idx   (rs2_lookup_idx),
    .rs2_lookup_data  (rs2_lookup_data),
    .rs2_lookup_ready (rs2_lookup_ready),
    .commit_valid     (commit_valid),
    .commit_entry     (commit_entry),
    .flush            (flush),
    .flush_pc         (flush_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fl;
    logic [31:0] fpc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] data,
                          input logic fl, input logic [31:0] fpc);
    exp_t e;
    e.pc = pc; e.data = data; e.fl = fl; e.fpc = fpc;
    exp_q.push_back(e);
  endtask

  // Monitor: every retiring entry must match the next expected commit.
  always @(negedge clk) begin
    if (!rst && commit_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_commit: pc 0x%08h retired, expected no commit", commit_entry.pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (commit_entry.pc !== mon_e.pc || commit_entry.rd_data !== mon_e.data ||
            flush !== mon_e.fl || flush_pc !== mon_e.fpc) begin
          n_err++;
          $display("FAIL commit: got pc=%08h data=%08h flush=%b flush_pc=%08h, expected pc=%08h data=%08h flush=%b flush_pc=%08h",
                   commit_entry.pc, commit_entry.rd_data, flush, flush_pc,
                   mon_e.pc, mon_e.data, mon_e.fl, mon_e.fpc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    dispatch_valid = 1'b0;
    wb_valid       = '0;
    wb_rob_idx     = '0;
    wb_data        = '0;
    wb_br_en       = 1'b0;
    wb_br_target   = '0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Dispatch image deliberately carries status=done/br_en=1 to prove they are overwritten.
  function automatic rob_entry_t mk(input logic [31:0] pc, input types_t op);
    rob_entry_t e;
    e         = '0;
    e.valid   = 1'b0;
    e.status  = done;
    e.op_type = op;
    e.pc      = pc;
    e.rd_addr = 5'd1;
    e.br_en   = 1'b1;
    return e;
  endfunction

  task automatic set_wb(input int p, input int idx, input logic [31:0] d);
    logic [31:0] iv;
    iv = idx;
    wb_valid[p]            = 1'b1;
    wb_rob_idx[p*IW +: IW] = iv[IW-1:0];
    wb_data[p*32 +: 32]    = d;
  endtask

  task automatic dispatch(input logic [31:0] pc, input types_t op, input int exp_idx);
    chk("dispatch_rob_idx", 32'(dispatch_rob_idx), exp_idx);
    dispatch_valid = 1'b1;
    dispatch_entry = mk(pc, op);
    tick();
    dispatch_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    clear_in();
    dispatch_entry = '0;
    rs1_lookup_idx = '0;
    rs2_lookup_idx = '0;

    // Reset state
    do_reset();
    chk("rst_dispatch_ready", 32'(dispatch_ready), 1);
    chk("rst_dispatch_rob_idx", 32'(dispatch_rob_idx), 0);
    chk("rst_commit_valid", 32'(commit_valid), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_flush_pc", flush_pc, 0);
    chk("rst_lookup_ready", 32'(rs1_lookup_ready), 0);

    // In-order commit with out-of-order writeback
    dispatch(32'h6000_0000, alu, 0);
    dispatch(32'h6000_0004, alu, 1);
    dispatch(32'h6000_0008, alu, 2);
    rs1_lookup_idx = 5'd1;
    set_wb(0, 1, 32'h11);
    tick(); clear_in();
    chk("ooo_head_blocked", 32'(commit_valid), 0);
    chk("ooo_lookup1_ready", 32'(rs1_lookup_ready), 1);
    chk("ooo_lookup1_data", rs1_lookup_data, 32'h11);
    push_exp(32'h6000_0000, 32'h10, 1'b0, 32'h0);
    push_exp(32'h6000_0004, 32'h11, 1'b0, 32'h0);
    set_wb(1, 0, 32'h10);
    tick(); clear_in();
    chk("ooo_commit0", 32'(commit_valid), 1);
    tick();
    chk("ooo_commit1", 32'(commit_valid), 1);
    tick();
    chk("ooo_idx2_waits", 32'(commit_valid), 0);
    tick();
    chk("ooo_idx2_still_waits", 32'(commit_valid), 0);
    // Port collision on idx2: port 3 must win over port 0
    push_exp(32'h6000_0008, 32'h12, 1'b0, 32'h0);
    set_wb(0, 2, 32'hBAD);
    set_wb(3, 2, 32'h12);
    tick(); clear_in();
    tick();
    chk("ooo_drained_commit", 32'(commit_valid), 0);
    chk("ooo_tail_idx", 32'(dispatch_rob_idx), 3);

    // Full: 32 allocations, 33rd ignored
    do_reset();
    for (int i = 0; i < 32; i++) dispatch(32'h6000_1000 + 32'(4 * i), alu, i);
    chk("full_ready", 32'(dispatch_ready), 0);
    chk("full_tail_idx", 32'(dispatch_rob_idx), 0);
    dispatch_valid = 1'b1;
    dispatch_entry = mk(32'h6000_1F00, alu);
    tick(); clear_in();
    chk("full_33rd_ready", 32'(dispatch_ready), 0);
    push_exp(32'h6000_1000, 32'h33, 1'b0, 32'h0);
    set_wb(0, 0, 32'h33);
    tick(); clear_in();
    chk("full_commit_valid", 32'(commit_valid), 1);
    chk("full_ready_same_cycle", 32'(dispatch_ready), 0);
    tick();
    chk("full_ready_after_commit", 32'(dispatch_ready), 1);
    chk("full_tail_after_commit", 32'(dispatch_rob_idx), 0);

    // Wrap: 40 entries streamed one per cycle
    do_reset();
    for (int i = 0; i <= 40; i++) begin
      if (i < 40) begin
        chk("wrap_ready", 32'(dispatch_ready), 1);
        chk("wrap_tail_idx", 32'(dispatch_rob_idx), i % 32);
        dispatch_valid = 1'b1;
        dispatch_entry = mk(32'h6000_3000 + 32'(4 * i), alu);
      end
      if (i >= 1) begin
        set_wb((i - 1) % 4, (i - 1) % 32, 32'hC0DE_0000 + 32'(i - 1));
        push_exp(32'h6000_3000 + 32'(4 * (i - 1)), 32'hC0DE_0000 + 32'(i - 1), 1'b0, 32'h0);
      end
      tick(); clear_in();
    end
    tick();
    tick();
    chk("wrap_idle", 32'(commit_valid), 0);
    chk("wrap_final_tail", 32'(dispatch_rob_idx), 8);

    // Taken branch at idx3 flushes idx4-6
    do_reset();
    for (int i = 0; i < 7; i++) dispatch(32'h6000_2000 + 32'(4 * i), (i == 3) ? br : alu, i);
    set_wb(0, 0, 32'hA0);
    set_wb(1, 1, 32'hA1);
    set_wb(3, 2, 32'hA2);
    set_wb(2, 3, 32'hA3);
    wb_br_en     = 1'b1;
    wb_br_target = 32'h6000_0100;
    push_exp(32'h6000_2000, 32'hA0, 1'b0, 32'h0);
    push_exp(32'h6000_2004, 32'hA1, 1'b0, 32'h0);
    push_exp(32'h6000_2008, 32'hA2, 1'b0, 32'h0);
    push_exp(32'h6000_200C, 32'hA3, 1'b1, 32'h6000_0100);
    tick(); clear_in();
    set_wb(0, 4, 32'hA4);
    tick(); clear_in();
    tick();
    tick();
    chk("br_flush", 32'(flush), 1);
    chk("br_flush_pc", flush_pc, 32'h6000_0100);
    chk("br_commit_valid", 32'(commit_valid), 1);
    dispatch_valid = 1'b1;
    dispatch_entry = mk(32'h6000_2FF0, alu);
    set_wb(0, 5, 32'hA5);
    tick(); clear_in();
    rs1_lookup_idx = 5'd4;
    #1;
    chk("br_after_flush", 32'(flush), 0);
    chk("br_after_flush_pc", flush_pc, 0);
    chk("br_after_commit", 32'(commit_valid), 0);
    chk("br_after_tail", 32'(dispatch_rob_idx), 4);
    chk("br_after_ready", 32'(dispatch_ready), 1);
    chk("br_idx4_gone", 32'(rs1_lookup_ready), 0);
    tick();
    tick();
    chk("br_no_late_commit", 32'(commit_valid), 0);
    chk("br_dispatch_dropped", 32'(dispatch_rob_idx), 4);

    // Lookup timing, then reset with live entries
    do_reset();
    for (int i = 0; i < 6; i++) dispatch(32'h6000_4000 + 32'(4 * i), alu, i);
    rs1_lookup_idx = 5'd5;
    rs2_lookup_idx = 5'd5;
    set_wb(0, 5, 32'hDEAD_BEEF);
    #1;
    chk("lookup_same_cycle", 32'(rs1_lookup_ready), 0);
    tick(); clear_in();
    chk("lookup_rs1_ready", 32'(rs1_lookup_ready), 1);
    chk("lookup_rs1_data", rs1_lookup_data, 32'hDEAD_BEEF);
    chk("lookup_rs2_ready", 32'(rs2_lookup_ready), 1);
    chk("lookup_rs2_data", rs2_lookup_data, 32'hDEAD_BEEF);
    for (int i = 6; i < 10; i++) dispatch(32'h6000_4000 + 32'(4 * i), alu, i);
    set_wb(0, 0, 32'h5);
    tick(); clear_in();
    chk("rst_pending_commit", 32'(commit_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_commit", 32'(commit_valid), 0);
    chk("rst_mid_tail", 32'(dispatch_rob_idx), 0);
    chk("rst_mid_ready", 32'(dispatch_ready), 1);
    chk("rst_mid_lookup", 32'(rs1_lookup_ready), 0);
    tick();
    tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
